// File: rtl/fir_lowpass_transposed_if.sv
// rtl/fir_lowpass_transposed_if.sv - sample stream into and filtered stream out of the FIR
interface fir_lowpass_transposed_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic signed [DATA_W-1:0] data_in;
  logic signed [OUT_W-1:0]  data_out;

  // Sample source side: drives samples, observes the filtered result.
  modport master (output data_in, input data_out);
  // Filter side.
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/fir_lowpass_transposed.sv
// rtl/fir_lowpass_transposed.sv - 11-tap fixed-coefficient low-pass FIR, transposed direct form
module fir_lowpass_transposed #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32,
  parameter int TAPS   = 11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  fir_lowpass_transposed_if.slave     bus
);

  // Symmetric low-pass set: DC gain 368, zero gain at Nyquist.
  localparam logic signed [COEF_W-1:0] COEF [TAPS] = '{
    -16'sd2, -16'sd4, 16'sd6, 16'sd40, 16'sd88, 16'sd112,
    16'sd88, 16'sd40, 16'sd6, -16'sd4, -16'sd2
  };

  logic signed [DATA_W-1:0] x_reg;
  logic signed [OUT_W-1:0]  x_ext;
  logic signed [OUT_W-1:0]  prod  [TAPS];
  logic signed [OUT_W-1:0]  p     [TAPS];
  logic signed [OUT_W-1:0]  out_reg;

  // Both operands are sign-extended to full width so the low OUT_W bits
  // of the product are the exact signed 16x16 result.
  assign x_ext = $signed({{(OUT_W-DATA_W){x_reg[DATA_W-1]}}, x_reg});

  // Every tap multiplies the same registered sample by its own coefficient.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = x_ext * $signed({{(OUT_W-COEF_W){COEF[k][COEF_W-1]}}, COEF[k]});
    end
  end

  // Input register, partial-sum chain p10 -> p0, and output register;
  // reset wipes all history so a restart behaves like a fresh filter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg   <= '0;
      out_reg <= '0;
      for (int k = 0; k < TAPS; k++) begin
        p[k] <= '0;
      end
    end else begin
      x_reg        <= bus.data_in;
      p[TAPS-1]    <= prod[TAPS-1];
      for (int k = 0; k < TAPS-1; k++) begin
        p[k] <= p[k+1] + prod[k];
      end
      out_reg      <= p[0];
    end
  end

  assign bus.data_out = out_reg;

endmodule

// File: tb/tb_fir_lowpass_transposed.sv
// tb/tb_fir_lowpass_transposed.sv - scoreboard bench for the transposed FIR
module tb_fir_lowpass_transposed;

  localparam int TAPS = 11;
  localparam int H    [TAPS] = '{-2, -4, 6, 40, 88, 112, 88, 40, 6, -4, -2};
  localparam int RAMP [TAPS] = '{-2000, -6000, 0, 40000, 128000, 240000,
                                 328000, 368000, 374000, 370000, 368000};
  localparam int AMP_EXP = 368 * 32767;
  localparam int AMP_TOL = 36175;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fir_lowpass_transposed_if fif ();

  fir_lowpass_transposed dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fif)
  );

  int errors = 0;
  int checks = 0;
  int hist [TAPS];
  int sb [$];
  int last_obs;
  int sine [512];
  int mx;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Zero-state model: the two queued zeros are the outputs of the first
  // two edges, before any sample can reach data_out.
  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    sb.delete();
    sb.push_back(0);
    sb.push_back(0);
  endtask

  // Called at a falling edge; ends at the next falling edge.
  task automatic step(input int d, input string tag);
    int e;
    fif.data_in = 16'(d);
    for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    e = 0;
    for (int k = 0; k < TAPS; k++) e += H[k] * hist[k];
    sb.push_back(e);
    @(posedge clk);
    #1;
    last_obs = fif.data_out;
    e = sb.pop_front();
    chk(tag, last_obs, e);
    @(negedge clk);
  endtask

  // Asserts reset between edges, holds it for a number of edges, and
  // releases at a falling edge so the next step is the first sampled edge.
  task automatic do_reset(input int d_hold, input int cycles);
    fif.data_in = 16'(d_hold);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", fif.data_out, 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", fif.data_out, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      sine[i] = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * i / 512.0) + 0.5));

    reset_n     = 1'b0;
    fif.data_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", fif.data_out, 0);
    reset_n = 1'b1;
    model_clear();

    // 1: reset pulse with a nonzero sample on the input
    step(0, "pre_rst");
    do_reset(1234, 10);

    // 2: impulse
    for (int i = 0; i < 15; i++) begin
      step((i == 0) ? 1 : 0, "imp_sb");
      if (i >= 2 && i <= 12) chk("imp_coef", last_obs, H[i-2]);
      else if (i > 12)       chk("imp_tail", last_obs, 0);
    end

    // 3: positive step
    for (int i = 0; i < 20; i++) begin
      step(1000, "pstep_sb");
      if (i >= 2 && i <= 12) chk("pstep_ramp", last_obs, RAMP[i-2]);
      if (i >= 12)           chk("pstep_settle", last_obs, 368000);
    end

    // 4: negative full-scale step from rest
    for (int i = 0; i < 13; i++) step(0, "flush");
    for (int i = 0; i < 20; i++) begin
      step(-32768, "nstep_sb");
      if (i == 4)  chk("nstep_mid", last_obs, 0);
      if (i >= 12) chk("nstep_settle", last_obs, -12058624);
    end

    // 5a: Nyquist tone is fully rejected once the window is filled
    for (int i = 0; i < 30; i++) begin
      step((i % 2 == 0) ? 1000 : -1000, "nyq_sb");
      if (i >= 12) chk("nyq_zero", last_obs, 0);
    end

    // 5b: low-frequency full-scale sine passes at DC gain
    mx = -2147483647;
    for (int i = 0; i < 812; i++) begin
      step(sine[i % 512], "sine_sb");
      if (i >= 300 && last_obs > mx) mx = last_obs;
    end
    checks++;
    assert (mx >= AMP_EXP - AMP_TOL && mx <= AMP_EXP + AMP_TOL) else begin
      errors++;
      $error("FAIL sine_amp observed=%0d expected=%0d+-%0d", mx, AMP_EXP, AMP_TOL);
    end

    // 6: reset in the middle of a step, ramp restarts from zero state
    for (int i = 0; i < 13; i++) step(0, "flush");
    for (int i = 0; i < 6; i++)  step(1000, "mid_pre");
    do_reset(1000, 10);
    for (int i = 0; i < 14; i++) begin
      step(1000, "mid_sb");
      if (i < 2)                    chk("mid_lat", last_obs, 0);
      else if (i <= 12)             chk("mid_ramp", last_obs, RAMP[i-2]);
      else                          chk("mid_settle", last_obs, 368000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
